// File: rtl/riscv_pkg.sv
// Shared integer-pipeline constants: data width, register address width and load funct3 codes.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/riscv_writeback_if.sv
// Bundle of the ALU/LSU result ports, issue port and register-file write port of the write-back stage.
interface riscv_writeback_if #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
);
    logic                          alu_valid;
    logic                          alu_ready;
    logic [riscv_pkg::REG_AW-1:0]  alu_rd;
    logic [XLEN-1:0]               alu_data;

    logic                          lsu_valid;
    logic                          lsu_ready;
    logic [riscv_pkg::REG_AW-1:0]  lsu_rd;
    logic [XLEN-1:0]               lsu_rdata;
    logic [2:0]                    lsu_funct3;
    logic [1:0]                    lsu_addr_lo;

    logic                          issue_valid;
    logic [riscv_pkg::REG_AW-1:0]  issue_rd;

    logic                          write_enable;
    logic [riscv_pkg::REG_AW-1:0]  write_addr;
    logic [XLEN-1:0]               write_data;
    logic [31:0]                   pending;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_rdata, lsu_funct3, lsu_addr_lo,
        output issue_valid, issue_rd,
        input  alu_ready, lsu_ready,
        input  write_enable, write_addr, write_data, pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_rdata, lsu_funct3, lsu_addr_lo,
        input  issue_valid, issue_rd,
        output alu_ready, lsu_ready,
        output write_enable, write_addr, write_data, pending
    );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with combinational head data; push/pop are ignored when full/empty.
module wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/riscv_writeback.sv
// Write-back sequencer: merges ALU and buffered LSU results into the single register-file
// write port and tracks which destinations still have a write in flight.
module riscv_writeback #(
    parameter int unsigned XLEN           = riscv_pkg::XLEN,
    parameter int unsigned LSU_FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    riscv_writeback_if.slave   bus
);
    import riscv_pkg::*;

    localparam int unsigned EntryW = REG_AW + XLEN;

    function automatic logic [XLEN-1:0] load_extend(
        input logic [XLEN-1:0] rdata,
        input logic [2:0]      funct3,
        input logic [1:0]      lo
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] res;
        b = rdata[{lo, 3'b000} +: 8];
        h = rdata[{lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   res = {{(XLEN-8){b[7]}}, b};
            F3_LBU:  res = {{(XLEN-8){1'b0}}, b};
            F3_LH:   res = {{(XLEN-16){h[15]}}, h};
            F3_LHU:  res = {{(XLEN-16){1'b0}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [EntryW-1:0] fifo_wdata, fifo_head;
    reg_addr_t         head_rd;
    logic [XLEN-1:0]   head_data;

    logic              commit;
    reg_addr_t         commit_rd;
    logic [XLEN-1:0]   commit_data;

    logic              write_enable_q, write_enable_d;
    reg_addr_t         write_addr_q, write_addr_d;
    logic [XLEN-1:0]   write_data_q, write_data_d;
    logic [31:0]       pending_q, pending_d;

    assign fifo_wdata = {bus.lsu_rd, load_extend(bus.lsu_rdata, bus.lsu_funct3, bus.lsu_addr_lo)};
    assign fifo_push  = bus.lsu_valid && !fifo_full;
    assign head_rd    = fifo_head[EntryW-1 -: REG_AW];
    assign head_data  = fifo_head[XLEN-1:0];

    wb_fifo #(
        .DEPTH (LSU_FIFO_DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A full FIFO pre-empts the ALU so loads can never starve.
    always_comb begin
        commit      = 1'b0;
        fifo_pop    = 1'b0;
        commit_rd   = '0;
        commit_data = '0;
        if (fifo_full) begin
            commit      = 1'b1;
            fifo_pop    = 1'b1;
            commit_rd   = head_rd;
            commit_data = head_data;
        end else if (bus.alu_valid) begin
            commit      = 1'b1;
            commit_rd   = bus.alu_rd;
            commit_data = bus.alu_data;
        end else if (!fifo_empty) begin
            commit      = 1'b1;
            fifo_pop    = 1'b1;
            commit_rd   = head_rd;
            commit_data = head_data;
        end
    end

    always_comb begin
        write_enable_d = commit && (commit_rd != '0);
        write_addr_d   = commit ? commit_rd   : write_addr_q;
        write_data_d   = commit ? commit_data : write_data_q;
        pending_d      = pending_q;
        if (commit && commit_rd != '0) begin
            pending_d[commit_rd] = 1'b0;
        end
        // Applied after the clear so a same-edge issue to the same register wins.
        if (bus.issue_valid && bus.issue_rd != '0) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            pending_q      <= '0;
        end else begin
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
            pending_q      <= pending_d;
        end
    end

    assign bus.alu_ready    = !fifo_full;
    assign bus.lsu_ready    = !fifo_full;
    assign bus.write_enable = write_enable_q;
    assign bus.write_addr   = write_addr_q;
    assign bus.write_data   = write_data_q;
    assign bus.pending      = pending_q;

endmodule

// File: tb/tb_riscv_writeback.sv
// Randomised and directed bench for riscv_writeback, checked by a cycle-tagged scoreboard.
module tb_riscv_writeback;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_writeback_if #(.XLEN(32)) bus ();

    riscv_writeback #(
        .XLEN           (32),
        .LSU_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        int          cyc;
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pend;
        bit          rdy;
    } exp_t;

    ent_t        mq[$];
    exp_t        eq[$];
    exp_t        mon_e;
    logic [31:0] mpend = '0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          alu_acc;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_ext(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [1:0] lo);
        logic [31:0] bv, hv;
        bv = (w >> (8 * int'(lo))) & 32'hFF;
        hv = (w >> (16 * (int'(lo) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (bv >= 32'd128) ? bv + 32'hFFFFFF00 : bv;
            3'd4:    return bv;
            3'd1:    return (hv >= 32'd32768) ? hv + 32'hFFFF0000 : hv;
            3'd5:    return hv;
            default: return w;
        endcase
    endfunction

    // Drive one cycle of stimulus, update the reference model and queue what must appear.
    task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] lw,
                         input logic [2:0] lf3, input logic [1:0] llo,
                         input bit iv, input logic [4:0] ird);
        ent_t c;
        bit   has_c;
        bit   full;
        exp_t e;
        bus.alu_valid   = av;  bus.alu_rd = ard;  bus.alu_data = ad;
        bus.lsu_valid   = lv;  bus.lsu_rd = lrd;  bus.lsu_rdata = lw;
        bus.lsu_funct3  = lf3; bus.lsu_addr_lo = llo;
        bus.issue_valid = iv;  bus.issue_rd = ird;
        c = '{rd: 5'd0, data: 32'd0};
        has_c = 0;
        alu_acc = 0;
        full = (mq.size() == DEPTH);
        if (full) begin
            c = mq.pop_front(); has_c = 1;
        end else if (av) begin
            c.rd = ard; c.data = ad; has_c = 1; alu_acc = 1;
        end else if (mq.size() > 0) begin
            c = mq.pop_front(); has_c = 1;
        end
        if (lv && !full) mq.push_back('{rd: lrd, data: model_ext(lw, lf3, llo)});
        if (has_c && c.rd != 0) mpend[c.rd] = 1'b0;
        if (iv && ird != 0) mpend[ird] = 1'b1;
        e.cyc  = cyc + 1;
        e.we   = has_c && (c.rd != 0);
        e.rd   = c.rd;
        e.data = c.data;
        e.pend = mpend;
        e.rdy  = (mq.size() != DEPTH);
        eq.push_back(e);
        @(posedge clk);
        #1;
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0; bus.issue_valid = 1'b0;
    endtask

    task automatic idle();
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 0, 5'd0);
    endtask

    // Monitor: compares DUT outputs against the record tagged for this cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            while (eq.size() > 0 && eq[0].cyc < cyc) begin
                mon_e = eq.pop_front();
                n_tests++; n_fail++;
                $display("FAIL stale_record: cycle %0d never checked, now %0d", mon_e.cyc, cyc);
            end
            if (eq.size() > 0 && eq[0].cyc == cyc) begin
                mon_e = eq.pop_front();
                check("write_enable", {31'd0, bus.write_enable}, {31'd0, mon_e.we});
                if (mon_e.we) begin
                    check("write_addr", {27'd0, bus.write_addr}, {27'd0, mon_e.rd});
                    check("write_data", bus.write_data, mon_e.data);
                end
                check("pending", bus.pending, mon_e.pend);
                check("alu_ready", {31'd0, bus.alu_ready}, {31'd0, mon_e.rdy});
                check("lsu_ready", {31'd0, bus.lsu_ready}, {31'd0, mon_e.rdy});
            end else if (bus.write_enable) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_write: addr %0d data %h, expected no write",
                         bus.write_addr, bus.write_data);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus.issue_valid && bus.issue_rd != 5'd0) begin
            assert (!bus.pending[bus.issue_rd])
            else $error("issue to register x%0d whose write is still pending", bus.issue_rd);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},   {31'd0, bus.write_enable}, 32'd0);
        check({tag, "_addr"}, {27'd0, bus.write_addr}, 32'd0);
        check({tag, "_data"}, bus.write_data, 32'd0);
        check({tag, "_pend"}, bus.pending, 32'd0);
        check({tag, "_alu_rdy"}, {31'd0, bus.alu_ready}, 32'd1);
        check({tag, "_lsu_rdy"}, {31'd0, bus.lsu_ready}, 32'd1);
    endtask

    logic [31:0] ld_word;
    logic [31:0] ld_exp [4];
    logic [2:0]  ld_f3  [4];
    logic [1:0]  ld_lo  [4];
    int          stall_cycles;
    int          loads_in;
    logic [31:0] alu_seq;
    bit          iv_r;
    logic [4:0]  ird_r;

    initial begin
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_rdata = 0;
        bus.lsu_funct3 = 0; bus.lsu_addr_lo = 0;
        bus.issue_valid = 0; bus.issue_rd = 0;

        #2;
        check_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Single ALU write clears a previously issued destination.
        cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 3'd0, 2'd0, 1, 5'd5);
        cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 3'd0, 2'd0, 0, 5'd0);
        @(negedge clk);
        check("alu_single_we", {31'd0, bus.write_enable}, 32'd1);
        check("alu_single_addr", {27'd0, bus.write_addr}, 32'd5);
        check("alu_single_data", bus.write_data, 32'hDEADBEEF);
        check("alu_single_pend5", {31'd0, bus.pending[5]}, 32'd0);

        // Load extraction, each visible two cycles after acceptance.
        ld_word = 32'h80FF7F01;
        ld_f3[0] = 3'b000; ld_lo[0] = 2'd3; ld_exp[0] = 32'hFFFFFF80;
        ld_f3[1] = 3'b100; ld_lo[1] = 2'd1; ld_exp[1] = 32'h0000007F;
        ld_f3[2] = 3'b001; ld_lo[2] = 2'd2; ld_exp[2] = 32'hFFFF80FF;
        ld_f3[3] = 3'b101; ld_lo[3] = 2'd0; ld_exp[3] = 32'h00007F01;
        for (int k = 0; k < 4; k++) begin
            cycle(0, 5'd0, 32'd0, 1, 5'(10 + k), ld_word, ld_f3[k], ld_lo[k], 0, 5'd0);
            idle();
            @(negedge clk);
            check("load_ext_data", bus.write_data, ld_exp[k]);
            check("load_ext_addr", {27'd0, bus.write_addr}, 32'(10 + k));
        end

        // ALU held valid while four loads arrive: one stall cycle, nothing lost.
        stall_cycles = 0;
        loads_in = 0;
        alu_seq = 32'h1000;
        for (int k = 0; k < 10; k++) begin
            if (!bus.alu_ready) stall_cycles++;
            cycle(1, 5'(1 + k % 3), alu_seq, loads_in < 4, 5'(20 + loads_in), 32'(100 + loads_in),
                  3'b010, 2'd0, 0, 5'd0);
            if (alu_acc) alu_seq++;
            if (loads_in < 4) loads_in++;
        end
        check("fair_stall_cycles", 32'(stall_cycles), 32'd1);
        for (int k = 0; k < 5; k++) idle();

        // x0 is consumed silently and never marked pending.
        check("x0_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        cycle(1, 5'd0, 32'h1234, 0, 5'd0, 32'd0, 3'd0, 2'd0, 1, 5'd0);
        @(negedge clk);
        check("x0_we", {31'd0, bus.write_enable}, 32'd0);
        check("x0_pend", bus.pending, 32'd0);

        // Same-edge issue and commit to x7: the issue wins.
        cycle(1, 5'd7, 32'h77, 0, 5'd0, 32'd0, 3'd0, 2'd0, 1, 5'd7);
        @(negedge clk);
        check("collide_pend7", {31'd0, bus.pending[7]}, 32'd1);
        cycle(1, 5'd7, 32'h78, 0, 5'd0, 32'd0, 3'd0, 2'd0, 0, 5'd0);
        @(negedge clk);
        check("collide_clear7", {31'd0, bus.pending[7]}, 32'd0);

        // Asynchronous reset with three loads buffered and a pending destination.
        for (int k = 0; k < 3; k++) begin
            cycle(1, 5'd3, 32'(200 + k), 1, 5'(25 + k), 32'(300 + k), 3'b010, 2'd0,
                  k == 0, 5'd9);
        end
        #2;
        rst_n = 1'b0;
        mq.delete();
        eq.delete();
        mpend = '0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) idle();

        // Randomised traffic with phases of varying ALU pressure.
        for (int i = 0; i < 1500; i++) begin
            iv_r  = ($urandom_range(0, 3) == 0);
            ird_r = 5'($urandom);
            if (iv_r && ird_r != 0 && mpend[ird_r]) iv_r = 0;
            cycle(($urandom_range(0, 9) < ((i / 100) % 3) * 4 + 1), 5'($urandom), $urandom,
                  ($urandom_range(0, 2) != 0), 5'($urandom), $urandom, 3'($urandom), 2'($urandom),
                  iv_r, ird_r);
        end
        for (int k = 0; k < 8; k++) idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
